cordic_arbiter: RTL and testbench
=================================

# cordic_arbiter

Round-robin arbiter that shares one CORDIC vectoring core and one CORDIC rotation core (rot1) among up to NUM_REQ independent requesters, such as the 5-D normaliser, the Gram-Schmidt deflation unit and the update unit. The arbiter grants exclusive, locked ownership of both cores to one requester at a time. It muxes the owner's command bus to the cores, routes the valid strobes back only to the owner, and flushes the cores between owners.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 32, signed Q12.20 data width
- CORDIC_STAGES, 32, micro-rotation vector width
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the macro)
- clk  in  1  clock
- nreset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester ownership request, level-held for the whole job
- grant  out  NUM_REQ  one-hot registered grant; all-zero when no owner
- r_vec_en, r_rot_en, r_nrst  in  NUM_REQ each  per-requester vec enable, rot enable, CORDIC soft reset
- r_vec_xin, r_vec_yin, r_rot_xin, r_rot_yin  in  NUM_REQ*DATA_WIDTH each  requester operands; slot i is at [i*DATA_WIDTH +: DATA_WIDTH]
- r_rot_microRot_in  in  NUM_REQ*CORDIC_STAGES  requester micro-rotation vectors
- r_rot_quad_in  in  NUM_REQ*2  requester quadrant codes
- c_vec_en, c_rot_en, c_nrst  out  1 each  to the cores
- c_vec_xin, c_vec_yin, c_rot_xin, c_rot_yin  out  DATA_WIDTH each  to the cores
- c_rot_microRot_in  out  CORDIC_STAGES  to rot1
- c_rot_quad_in  out  2  to rot1
- c_vec_opvld, c_rot_opvld  in  1 each  core result strobes
- r_vec_opvld, r_rot_opvld  out  NUM_REQ each  strobes demuxed to the owner only
- busy  out  1  high whenever grant is non-zero or the state is FLUSH
- timeout_err  out  1  one-cycle pulse on a watchdog revoke (tied 0 without the macro)

## Operation
- States:
  - IDLE: no owner.
  - OWN: grant is held.
  - FLUSH: one cycle; cores are held in reset.
- IDLE: if any req bit is set, grant the first set bit scanning upward from ptr and wrapping around, then go to OWN. Otherwise stay in IDLE.
- OWN: while req[owner] is 1, stay in OWN. When req[owner] drops to 0, clear grant, go to FLUSH, and set ptr to (owner+1) mod NUM_REQ.
- FLUSH: force c_nrst=0, c_vec_en=0 and c_rot_en=0. Arbitrate exactly as in IDLE: go to OWN if any req is set, else to IDLE.
- Output mux:
  - While granted, all c_* outputs equal the owner's r_* slice, including c_nrst=r_nrst[owner].
  - When no owner is granted, every c_* output is 0.
- Return routing:
  - r_vec_opvld[i] = c_vec_opvld & grant[i].
  - r_rot_opvld[i] = c_rot_opvld & grant[i].
  - Result data is broadcast by the top level and is not handled here.
- Pure muxing: no width change and no arithmetic on the data paths.
- Strobe in FLUSH or IDLE: a c_*_opvld that arrives in either state is dropped and not forwarded.

## Timing
- Reset (asynchronous): state=IDLE, ptr=0, grant=0, busy=0, timeout_err=0, all c_* outputs 0.
- Grant latency: req rising at edge t in IDLE gives grant at t+1. The mux outputs follow the grant combinationally in the same cycle.
- Handover: req[owner] low at t gives grant=0 and FLUSH at t+1. The next grant appears at t+2 at the earliest.
- The old owner re-requesting during FLUSH has the lowest priority because ptr has already advanced.
- Simultaneous requests in IDLE: the lowest index at or above ptr wins.
- Reset asserted mid-job: the arbiter returns to the reset values immediately. No partial handover occurs.

## Configuration
- CORDIC_ARB_TIMEOUT_EN defined:
  - A watchdog counter clears on grant and on any c_vec_opvld or c_rot_opvld.
  - It increments every cycle in OWN.
  - On reaching TIMEOUT_CYCLES, the arbiter revokes the grant, enters FLUSH, advances ptr, and pulses timeout_err for one cycle.
  - The revoked requester must drop req before it is granted again.
- CORDIC_ARB_TIMEOUT_EN undefined: no counter, timeout_err is tied to 0, and ownership is unbounded.

## Test plan
- Single requester: req=3'b001 held; r_vec_xin[0]=0x00100000 gives grant=001 one cycle later and c_vec_xin=0x00100000. c_vec_opvld appears only on r_vec_opvld[0].
- Contention: req=3'b111 from reset gives grant order 001, 010, 100, 001. Each request drops after 10 cycles. Every handover has exactly one FLUSH cycle with c_nrst=0.
- Strobe isolation: while 2 owns the cores, pulse c_rot_opvld. Expect r_rot_opvld=100 and nothing on 0 or 1. A c_rot_opvld pulse in FLUSH reaches no requester.
- Re-request: requester 0 drops req and reasserts it during FLUSH while requester 1 is waiting. Requester 1 wins.
- Reset mid-job: nreset pulses low during OWN. grant, busy and all c_* outputs go to 0 asynchronously, and ptr=0 afterwards.
- Timeout (macro on, TIMEOUT_CYCLES=16): the owner holds req with no opvld. Expect revoke after 16 cycles, a one-cycle timeout_err pulse, and the next requester granted.

Source files
------------

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin, lock-until-release arbiter sharing one CORDIC
// vectoring core and one CORDIC rotation core among NUM_REQ requesters.
//
// Optional feature macro: CORDIC_ARB_TIMEOUT_EN
//   defined   -> ownership watchdog revokes a stalled owner after TIMEOUT_CYCLES
//   undefined -> ownership is unbounded, timeout_err tied to 0
//
// Ports
//   clk, nreset          clock, asynchronous active-low reset
//   req                  per-requester ownership request (level, held per job)
//   grant                one-hot registered grant, zero when no owner
//   r_*  (inputs)        per-requester command slices, slot i at [i*W +: W]
//   c_*  (outputs)       command bus to the cores, the owner's slice or zero
//   c_vec/rot_opvld      core result strobes
//   r_vec/rot_opvld      result strobes demuxed to the owner only
//   busy                 grant non-zero or flushing
//   timeout_err          one-cycle pulse on a watchdog revoke
module cordic_arbiter #(
   parameter int unsigned NUM_REQ        = 3,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned CORDIC_STAGES  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk,
   input  logic                              nreset,
   input  logic [NUM_REQ-1:0]                req,
   output logic [NUM_REQ-1:0]                grant,
   input  logic [NUM_REQ-1:0]                r_vec_en,
   input  logic [NUM_REQ-1:0]                r_rot_en,
   input  logic [NUM_REQ-1:0]                r_nrst,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     r_vec_xin,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     r_vec_yin,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     r_rot_xin,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     r_rot_yin,
   input  logic [NUM_REQ*CORDIC_STAGES-1:0]  r_rot_microRot_in,
   input  logic [NUM_REQ*2-1:0]              r_rot_quad_in,
   output logic                              c_vec_en,
   output logic                              c_rot_en,
   output logic                              c_nrst,
   output logic [DATA_WIDTH-1:0]             c_vec_xin,
   output logic [DATA_WIDTH-1:0]             c_vec_yin,
   output logic [DATA_WIDTH-1:0]             c_rot_xin,
   output logic [DATA_WIDTH-1:0]             c_rot_yin,
   output logic [CORDIC_STAGES-1:0]          c_rot_microRot_in,
   output logic [1:0]                        c_rot_quad_in,
   input  logic                              c_vec_opvld,
   input  logic                              c_rot_opvld,
   output logic [NUM_REQ-1:0]                r_vec_opvld,
   output logic [NUM_REQ-1:0]                r_rot_opvld,
   output logic                              busy,
   output logic                              timeout_err
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Elaboration-time parameter sanity check
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 ||
       DATA_WIDTH == 0 || CORDIC_STAGES == 0) begin : g_param_err
      $error("cordic_arbiter: illegal parameter value");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t             r_state, w_state_nx;
   logic [IDX_W-1:0]   r_ptr, w_ptr_nx;
   logic [IDX_W-1:0]   r_owner, w_owner_nx;
   logic [NUM_REQ-1:0] r_grant, w_grant_nx;
   logic [NUM_REQ-1:0] w_req_eff;
   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_pick_found;
   logic [IDX_W-1:0]   w_owner_inc;
   logic               w_timeout;
   logic               w_opvld_any;

   assign w_opvld_any = c_vec_opvld | c_rot_opvld;

`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0]   r_wdog_cnt;
   logic [NUM_REQ-1:0] r_blocked;
   logic               r_timeout_err;

   // Stalled owner: still requesting, no strobe, counter at its last count
   assign w_timeout = (r_state == S_OWN) && req[r_owner] && !w_opvld_any &&
                      (r_wdog_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // A revoked requester stays masked until it drops req
   assign w_req_eff = req & ~r_blocked;

   // Watchdog counter, blocked mask and error pulse
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_wdog_cnt    <= '0;
         r_blocked     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         r_blocked     <= (r_blocked & req) | (w_timeout ? r_grant : '0);
         if (r_state == S_OWN && !w_opvld_any)
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
         else
            r_wdog_cnt <= '0;
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout   = 1'b0;
   assign w_req_eff   = req;
   assign timeout_err = 1'b0;
`endif

   // First set request at or above ptr, wrapping around
   always_comb begin
      int unsigned v_idx;
      v_idx        = 0;
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         v_idx = 32'(r_ptr) + k;
         if (v_idx >= NUM_REQ)
            v_idx = v_idx - NUM_REQ;
         if (!w_pick_found && w_req_eff[IDX_W'(v_idx)]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = IDX_W'(v_idx);
         end
      end
   end

   assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

   // Next-state logic
   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_owner_nx = r_owner;
      w_grant_nx = r_grant;
      case (r_state)
         S_IDLE, S_FLUSH: begin
            if (w_pick_found) begin
               w_state_nx = S_OWN;
               w_owner_nx = w_pick_idx;
               w_grant_nx = NUM_REQ'(1) << w_pick_idx;
            end else begin
               w_state_nx = S_IDLE;
               w_grant_nx = '0;
            end
         end
         S_OWN: begin
            if (!req[r_owner] || w_timeout) begin
               w_state_nx = S_FLUSH;
               w_grant_nx = '0;
               w_ptr_nx   = w_owner_inc;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_grant_nx = '0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_grant <= '0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
         r_owner <= w_owner_nx;
         r_grant <= w_grant_nx;
      end
   end

   assign grant = r_grant;
   assign busy  = (r_grant != '0) || (r_state == S_FLUSH);

   // AND-OR command mux; grant is zero in IDLE/FLUSH so the cores see all
   // zeros there, which also holds them in reset (c_nrst=0) during FLUSH
   always_comb begin
      c_vec_en          = 1'b0;
      c_rot_en          = 1'b0;
      c_nrst            = 1'b0;
      c_vec_xin         = '0;
      c_vec_yin         = '0;
      c_rot_xin         = '0;
      c_rot_yin         = '0;
      c_rot_microRot_in = '0;
      c_rot_quad_in     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            c_vec_en          = c_vec_en | r_vec_en[i];
            c_rot_en          = c_rot_en | r_rot_en[i];
            c_nrst            = c_nrst   | r_nrst[i];
            c_vec_xin         = c_vec_xin | r_vec_xin[i*DATA_WIDTH +: DATA_WIDTH];
            c_vec_yin         = c_vec_yin | r_vec_yin[i*DATA_WIDTH +: DATA_WIDTH];
            c_rot_xin         = c_rot_xin | r_rot_xin[i*DATA_WIDTH +: DATA_WIDTH];
            c_rot_yin         = c_rot_yin | r_rot_yin[i*DATA_WIDTH +: DATA_WIDTH];
            c_rot_microRot_in = c_rot_microRot_in |
                                r_rot_microRot_in[i*CORDIC_STAGES +: CORDIC_STAGES];
            c_rot_quad_in     = c_rot_quad_in | r_rot_quad_in[i*2 +: 2];
         end
      end
   end

   // Strobes reach the owner only; dropped in IDLE/FLUSH
   assign r_vec_opvld = {NUM_REQ{c_vec_opvld}} & r_grant;
   assign r_rot_opvld = {NUM_REQ{c_rot_opvld}} & r_grant;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: stimulus pushes expected grants and
// strobes into queues, a negedge monitor pops and compares.
module tb_cordic_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned CS = 32;
`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int unsigned TO = 16;
`else
   localparam int unsigned TO = 1024;
`endif

   logic              clk = 1'b0;
   logic              nreset = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR-1:0]     grant;
   logic [NR-1:0]     r_vec_en = '1, r_rot_en = '1, r_nrst = '1;
   logic [NR*DW-1:0]  r_vec_xin, r_vec_yin, r_rot_xin, r_rot_yin;
   logic [NR*CS-1:0]  r_rot_microRot_in;
   logic [NR*2-1:0]   r_rot_quad_in;
   logic              c_vec_en, c_rot_en, c_nrst;
   logic [DW-1:0]     c_vec_xin, c_vec_yin, c_rot_xin, c_rot_yin;
   logic [CS-1:0]     c_rot_microRot_in;
   logic [1:0]        c_rot_quad_in;
   logic              c_vec_opvld = 1'b0, c_rot_opvld = 1'b0;
   logic [NR-1:0]     r_vec_opvld, r_rot_opvld;
   logic              busy, timeout_err;

   int n_chk = 0;
   int n_err = 0;

   logic [NR-1:0] q_grant[$];
   logic [NR-1:0] q_vop[$];
   logic [NR-1:0] q_rop[$];
   logic [NR-1:0] prev_g = '0;

   cordic_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CORDIC_STAGES(CS),
                    .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .nreset(nreset), .req(req), .grant(grant),
      .r_vec_en(r_vec_en), .r_rot_en(r_rot_en), .r_nrst(r_nrst),
      .r_vec_xin(r_vec_xin), .r_vec_yin(r_vec_yin),
      .r_rot_xin(r_rot_xin), .r_rot_yin(r_rot_yin),
      .r_rot_microRot_in(r_rot_microRot_in), .r_rot_quad_in(r_rot_quad_in),
      .c_vec_en(c_vec_en), .c_rot_en(c_rot_en), .c_nrst(c_nrst),
      .c_vec_xin(c_vec_xin), .c_vec_yin(c_vec_yin),
      .c_rot_xin(c_rot_xin), .c_rot_yin(c_rot_yin),
      .c_rot_microRot_in(c_rot_microRot_in), .c_rot_quad_in(c_rot_quad_in),
      .c_vec_opvld(c_vec_opvld), .c_rot_opvld(c_rot_opvld),
      .r_vec_opvld(r_vec_opvld), .r_rot_opvld(r_rot_opvld),
      .busy(busy), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Operand of requester i as loaded below
   function automatic logic [DW-1:0] exp_xin(input logic [NR-1:0] g);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < int'(NR); i++)
         if (g[i]) v = 32'h0010_0000 + 32'(i);
      return v;
   endfunction

   function automatic logic [NR-1:0] oh(input int i);
      logic [NR-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_grant(input logic [NR-1:0] exp, input string nm);
      int k;
      k = 0;
      while (grant !== exp && k < 20) begin
         cyc(1);
         k++;
      end
      chk(nm, 64'(grant), 64'(exp));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 nreset = 1'b0;
      req = '0;
      cyc(2);
      nreset = 1'b1;
      cyc(1);
   endtask

   // Monitor: compare new grants, flush cycles and forwarded strobes
   always @(negedge clk) begin
      if (!nreset) begin
         prev_g = '0;
      end else begin
         if (grant != prev_g && grant != '0) begin
            if (q_grant.size() == 0) begin
               chk("unexpected_grant", 64'(grant), 64'(0));
            end else begin
               logic [NR-1:0] e;
               e = q_grant.pop_front();
               chk("sb_grant", 64'(grant), 64'(e));
               chk("sb_c_vec_xin", 64'(c_vec_xin), 64'(exp_xin(e)));
               chk("sb_c_nrst_own", 64'(c_nrst), 64'(1));
            end
         end
         if (grant == '0 && prev_g != '0) begin
            chk("flush_c_nrst", 64'(c_nrst), 64'(0));
            chk("flush_c_vec_en", 64'(c_vec_en), 64'(0));
            chk("flush_busy", 64'(busy), 64'(1));
         end
         if (r_vec_opvld != '0) begin
            if (q_vop.size() == 0) chk("unexpected_vec_opvld", 64'(r_vec_opvld), 64'(0));
            else chk("sb_vec_opvld", 64'(r_vec_opvld), 64'(q_vop.pop_front()));
         end
         if (r_rot_opvld != '0) begin
            if (q_rop.size() == 0) chk("unexpected_rot_opvld", 64'(r_rot_opvld), 64'(0));
            else chk("sb_rot_opvld", 64'(r_rot_opvld), 64'(q_rop.pop_front()));
         end
         prev_g = grant;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: got timeout expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      for (int i = 0; i < int'(NR); i++) begin
         r_vec_xin[i*DW +: DW]         = 32'h0010_0000 + 32'(i);
         r_vec_yin[i*DW +: DW]         = 32'h0020_0000 + 32'(i);
         r_rot_xin[i*DW +: DW]         = 32'h0030_0000 + 32'(i);
         r_rot_yin[i*DW +: DW]         = 32'h0040_0000 + 32'(i);
         r_rot_microRot_in[i*CS +: CS] = 32'hA5A5_0000 + 32'(i);
         r_rot_quad_in[i*2 +: 2]       = 2'(i + 1);
      end

      // Reset values
      #12;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_timeout_err", 64'(timeout_err), 64'(0));
      chk("rst_c_vec_xin", 64'(c_vec_xin), 64'(0));
      chk("rst_c_nrst", 64'(c_nrst), 64'(0));
      chk("rst_c_rot_quad", 64'(c_rot_quad_in), 64'(0));
      @(posedge clk);
      #1 nreset = 1'b1;
      cyc(1);

      // Single requester: one-cycle grant latency, strobe to requester 0
      q_grant.push_back(3'b001);
      req = 3'b001;
      cyc(1);
      chk("single_latency", 64'(grant), 64'(3'b001));
      chk("single_c_vec_xin", 64'(c_vec_xin), 64'(32'h0010_0000));
      chk("single_quad", 64'(c_rot_quad_in), 64'(2'd1));
      q_vop.push_back(3'b001);
      c_vec_opvld = 1'b1;
      cyc(1);
      c_vec_opvld = 1'b0;
      cyc(2);
      req = 3'b000;
      cyc(3);

      // Contention from reset: 0,1,2,0 with one flush cycle per handover
      do_reset();
      q_grant.push_back(3'b001);
      q_grant.push_back(3'b010);
      q_grant.push_back(3'b100);
      q_grant.push_back(3'b001);
      req = 3'b111;
      for (int n = 0; n < 4; n++) begin
         wait_grant(oh(n % 3), "cont_grant");
         cyc(10);
         if (n == 3) begin
            req = '0;
         end else begin
            req = req & ~oh(n % 3);
            cyc(1);
            chk("cont_flush_grant", 64'(grant), 64'(0));
            chk("cont_flush_busy", 64'(busy), 64'(1));
            chk("cont_flush_nrst", 64'(c_nrst), 64'(0));
            cyc(1);
            chk("cont_next", 64'(grant), 64'(oh((n + 1) % 3)));
            req = req | oh(n % 3);
         end
      end
      cyc(3);

      // Strobe isolation: owner 2 only; strobe in FLUSH dropped
      q_grant.push_back(3'b100);
      req = 3'b100;
      wait_grant(3'b100, "iso_grant");
      q_rop.push_back(3'b100);
      c_rot_opvld = 1'b1;
      cyc(1);
      c_rot_opvld = 1'b0;
      req = 3'b000;
      cyc(1);
      c_rot_opvld = 1'b1;
      #2 chk("flush_rot_strobe", 64'(r_rot_opvld), 64'(0));
      cyc(1);
      c_rot_opvld = 1'b0;
      cyc(2);

      // Re-request during FLUSH loses to the waiting requester
      q_grant.push_back(3'b001);
      req = 3'b001;
      wait_grant(3'b001, "rereq_first");
      req = 3'b011;
      cyc(2);
      q_grant.push_back(3'b010);
      req = 3'b010;
      cyc(1);
      chk("rereq_flush", 64'(grant), 64'(0));
      req = 3'b011;
      cyc(1);
      chk("rereq_winner", 64'(grant), 64'(3'b010));
      q_grant.push_back(3'b001);
      req = 3'b001;
      wait_grant(3'b001, "rereq_after");
      req = 3'b000;
      cyc(3);

      // Reset mid-job: asynchronous clear, ptr back to 0
      q_grant.push_back(3'b100);
      req = 3'b100;
      wait_grant(3'b100, "mid_grant");
      @(posedge clk);
      #2 nreset = 1'b0;
      #2;
      chk("arst_grant", 64'(grant), 64'(0));
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_c_vec_xin", 64'(c_vec_xin), 64'(0));
      chk("arst_c_vec_en", 64'(c_vec_en), 64'(0));
      req = 3'b011;
      cyc(1);
      q_grant.push_back(3'b001);
      nreset = 1'b1;
      wait_grant(3'b001, "post_reset_ptr");
      req = 3'b000;
      cyc(3);

`ifdef CORDIC_ARB_TIMEOUT_EN
      // Watchdog: revoke after TO cycles, pulse, next requester, block
      q_grant.push_back(3'b001);
      q_grant.push_back(3'b010);
      req = 3'b011;
      wait_grant(3'b001, "to_grant");
      cyc(TO - 1);
      chk("to_still_owned", 64'(grant), 64'(3'b001));
      cyc(1);
      chk("to_revoked", 64'(grant), 64'(0));
      chk("to_err_pulse", 64'(timeout_err), 64'(1));
      cyc(1);
      chk("to_next", 64'(grant), 64'(3'b010));
      chk("to_err_low", 64'(timeout_err), 64'(0));
      req = 3'b001;
      cyc(4);
      chk("to_blocked", 64'(grant), 64'(0));
      req = 3'b000;
      cyc(1);
      q_grant.push_back(3'b001);
      req = 3'b001;
      wait_grant(3'b001, "to_regrant");
      req = 3'b000;
      cyc(3);
`endif

      chk("sb_grant_drained", 64'(q_grant.size()), 64'(0));
      chk("sb_vop_drained", 64'(q_vop.size()), 64'(0));
      chk("sb_rop_drained", 64'(q_rop.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
